// File: rtl/swim_cmd_ctrl.sv
// swim_cmd_ctrl: host opcode sequencer driving the SWIM entry and frame engines.
// Define SWIM_TIMEOUT_EN to add a watchdog on every engine wait state.
module swim_cmd_ctrl #(
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 480000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       entry_start,
  input  logic       entry_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic [3:0] tx_nbits,
  input  logic       tx_done,
  input  logic       tx_ack,
  output logic       rx_start,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       busy
);
  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [3:0] {
    IDLE, ARGS, ENTRY_WAIT, TX_ISSUE, TX_WAIT, RX_ISSUE,
    RX_WAIT, WDATA, RSP_DATA, RSP_STATUS, DRAIN
  } state_t;

  state_t        state, state_n;
  logic [1:0]    op, acnt, ph;
  logic [2:0]    fidx;
  logic [7:0]    n, ah, am, al, wbyte, bcnt, stat;
  logic [7:0]    code, frame;
  logic [RW-1:0] retry;
  logic          cmd_fire, rsp_fire, fail, finish, tmo;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign rsp_fire = rsp_valid && rsp_ready;
  assign busy     = state != IDLE;

`ifdef SWIM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wdog;
  logic          waiting;

  assign waiting = state inside {ENTRY_WAIT, TX_WAIT, RX_WAIT};
  assign tmo     = waiting && wdog == TW'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (reset || !waiting || state_n != state) wdog <= '0;
    else wdog <= wdog + TW'(1);
  end
`else
  assign tmo = 1'b0;
`endif

  // Frame 0 is the 3-bit SWIM command, then N/AH/AM/AL, then payload.
  always_comb begin
    frame = wbyte;
    case (fidx)
      3'd0:    frame = {5'b0, 1'b0, op == 2'd3, op == 2'd2};
      3'd1:    frame = n;
      3'd2:    frame = ah;
      3'd3:    frame = am;
      3'd4:    frame = al;
      default: frame = wbyte;
    endcase
  end

  always_comb begin
    state_n = state;
    fail    = 1'b0;
    finish  = 1'b0;
    code    = 8'h00;
    case (state)
      IDLE: if (cmd_fire) begin
        if (cmd_data == 8'h00) state_n = ENTRY_WAIT;
        else if (cmd_data == 8'h01) state_n = TX_ISSUE;
        else if (cmd_data == 8'h02 || cmd_data == 8'h03) state_n = ARGS;
        else begin
          finish = 1'b1;
          code   = 8'hF0;
        end
      end
      ARGS: if (cmd_fire && acnt == 2'd3) begin
        if (n == 8'd0) begin
          finish = 1'b1;
          code   = {6'b111100, op};
        end else state_n = TX_ISSUE;
      end
      ENTRY_WAIT: if (ph == 2'd3 && !entry_busy) begin
        finish = 1'b1;
        code   = 8'h80;
      end
      TX_ISSUE: state_n = TX_WAIT;
      TX_WAIT: if (tx_done) begin
        if (!tx_ack) begin
          if (retry == RW'(MAX_RETRY)) begin
            fail = 1'b1;
            code = {6'b111000, op};
          end else state_n = TX_ISSUE;
        end else if (op == 2'd1 || (fidx == 3'd5 && bcnt == 8'd0)) begin
          finish = 1'b1;
          code   = {6'b100000, op};
        end else if (fidx < 3'd4) state_n = TX_ISSUE;
        else if (fidx == 3'd4 && op == 2'd2) state_n = RX_ISSUE;
        else state_n = WDATA;
      end
      RX_ISSUE: state_n = RX_WAIT;
      RX_WAIT: if (rx_done) state_n = RSP_DATA;
      WDATA: if (cmd_fire) state_n = TX_ISSUE;
      RSP_DATA: if (rsp_fire) begin
        if (bcnt == 8'd0) begin
          finish = 1'b1;
          code   = {6'b100000, op};
        end else state_n = RX_ISSUE;
      end
      RSP_STATUS: if (rsp_fire) state_n = IDLE;
      DRAIN: if (cmd_fire && bcnt == 8'd1) begin
        finish = 1'b1;
        code   = stat;
      end
      default: state_n = IDLE;
    endcase
    if (tmo) begin
      finish = 1'b0;
      fail   = 1'b1;
      code   = {6'b110100, op};
    end
    // An aborted WOTF must swallow its unsent payload before reporting.
    if (fail && op == 2'd3 && bcnt != 8'd0) state_n = DRAIN;
    else if (fail || finish) state_n = RSP_STATUS;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      op          <= 2'd0;
      acnt        <= 2'd0;
      ph          <= 2'd0;
      fidx        <= 3'd0;
      n           <= 8'd0;
      ah          <= 8'd0;
      am          <= 8'd0;
      al          <= 8'd0;
      wbyte       <= 8'd0;
      bcnt        <= 8'd0;
      stat        <= 8'd0;
      retry       <= '0;
      cmd_ready   <= 1'b0;
      rsp_data    <= 8'd0;
      rsp_valid   <= 1'b0;
      entry_start <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= 8'd0;
      tx_nbits    <= 4'd0;
      rx_start    <= 1'b0;
    end else begin
      state       <= state_n;
      cmd_ready   <= state_n inside {IDLE, ARGS, WDATA, DRAIN};
      rsp_valid   <= state_n inside {RSP_DATA, RSP_STATUS};
      entry_start <= state == ENTRY_WAIT && ph == 2'd0;
      tx_start    <= state == TX_ISSUE;
      rx_start    <= state == RX_ISSUE;
      if (state_n == DRAIN && state != DRAIN) stat <= code;
      if (state_n == RSP_STATUS && (fail || finish)) rsp_data <= code;
      else if (state == RX_WAIT && state_n == RSP_DATA) rsp_data <= rx_data;
      case (state)
        IDLE: if (cmd_fire) begin
          op    <= cmd_data[1:0];
          acnt  <= 2'd0;
          ph    <= 2'd0;
          fidx  <= 3'd0;
          bcnt  <= 8'd0;
          retry <= '0;
        end
        ARGS: if (cmd_fire) begin
          acnt <= acnt + 2'd1;
          case (acnt)
            2'd0: n  <= cmd_data;
            2'd1: ah <= cmd_data;
            2'd2: am <= cmd_data;
            default: begin
              al   <= cmd_data;
              bcnt <= n;
            end
          endcase
        end
        ENTRY_WAIT: if (ph != 2'd3) ph <= ph + 2'd1;
        TX_ISSUE: begin
          tx_data  <= frame;
          tx_nbits <= (fidx == 3'd0) ? 4'd3 : 4'd8;
        end
        TX_WAIT: if (tx_done) begin
          if (tx_ack) begin
            retry <= '0;
            if (fidx != 3'd5) fidx <= fidx + 3'd1;
          end else retry <= retry + RW'(1);
        end
        RX_WAIT: if (rx_done) bcnt <= bcnt - 8'd1;
        WDATA, DRAIN: if (cmd_fire) begin
          wbyte <= cmd_data;
          bcnt  <= bcnt - 8'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_swim_cmd_ctrl.sv
// tb_swim_cmd_ctrl: scoreboard bench for swim_cmd_ctrl with behavioural
// entry/TX/RX engine models.
module tb_swim_cmd_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] rsp_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       entry_start;
  logic       entry_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] tx_nbits;
  logic       tx_done;
  logic       tx_ack;
  logic       rx_start;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       busy;

  swim_cmd_ctrl dut (
    .clk(clk), .reset(reset),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .entry_start(entry_start), .entry_busy(entry_busy),
    .tx_start(tx_start), .tx_data(tx_data), .tx_nbits(tx_nbits),
    .tx_done(tx_done), .tx_ack(tx_ack),
    .rx_start(rx_start), .rx_done(rx_done), .rx_data(rx_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int ent_cnt = 0;
  logic rx_hold = 1'b0;

  logic [7:0]  exp_rsp[$];
  logic [11:0] exp_tx[$];
  logic        ack_q[$];
  logic [7:0]  rx_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic frm(input logic [3:0] nb, input logic [7:0] d);
    exp_tx.push_back({nb, d});
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    cmd_data  = b;
    cmd_valid = 1'b1;
    while (!cmd_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk("cmd_accept_timeout", 32'(b), 32'hFFFF);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    while ((busy || exp_rsp.size() != 0) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_finish"}, 32'(t < 20000), 32'd1);
    chk({nm, "_tx_left"}, exp_tx.size(), 0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
  endtask

  // TX engine: done 3 cycles after start; ACK follows the plan queue.
  initial begin
    tx_done = 1'b0;
    tx_ack  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_start) begin
        if (exp_tx.size() == 0) begin
          n_chk++;
          $display("FAIL tx_unexpected: got %0h/%0h expected none", tx_nbits, tx_data);
        end else chk("tx_frame", {tx_nbits, tx_data}, exp_tx.pop_front());
        repeat (3) @(posedge clk);
        #1;
        tx_done = 1'b1;
        tx_ack  = (ack_q.size() != 0) ? ack_q.pop_front() : 1'b1;
        @(posedge clk);
        #1;
        tx_done = 1'b0;
        tx_ack  = 1'b0;
      end
    end
  end

  initial begin
    rx_done = 1'b0;
    rx_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rx_start) begin
        repeat (2) @(posedge clk);
        #1;
        if (!rx_hold) begin
          rx_done = 1'b1;
          rx_data = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
          @(posedge clk);
          #1;
          rx_done = 1'b0;
        end
      end
    end
  end

  initial begin
    entry_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (entry_start) begin
        ent_cnt++;
        entry_busy = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        entry_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_rsp.size() == 0) begin
        n_chk++;
        $display("FAIL rsp_unexpected: got %0h expected none", rsp_data);
      end else chk("rsp", 32'(rsp_data), 32'(exp_rsp.pop_front()));
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    logic [7:0] held;
    logic       stable;
    int         t;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_strobes", {tx_start, rx_start, entry_start}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // ENTRY
    exp_rsp.push_back(8'h80);
    send(8'h00);
    wait_idle("entry");
    chk("entry_pulses", ent_cnt, 1);

    // SRST
    frm(4'd3, 8'h00);
    exp_rsp.push_back(8'h81);
    send(8'h01);
    wait_idle("srst");

    // ROTF 3 bytes
    frm(4'd3, 8'h01); frm(4'd8, 8'h03); frm(4'd8, 8'h00);
    frm(4'd8, 8'h50); frm(4'd8, 8'h00);
    rx_q = '{8'hAA, 8'hBB, 8'hCC};
    exp_rsp = '{8'hAA, 8'hBB, 8'hCC, 8'h82};
    send(8'h02); send(8'h03); send(8'h00); send(8'h50); send(8'h00);
    wait_idle("rotf");

    // WOTF with the 0x11 frame NACKed twice
    frm(4'd3, 8'h02); frm(4'd8, 8'h02); frm(4'd8, 8'h00);
    frm(4'd8, 8'h50); frm(4'd8, 8'h00);
    frm(4'd8, 8'h11); frm(4'd8, 8'h11); frm(4'd8, 8'h11); frm(4'd8, 8'h22);
    ack_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_rsp.push_back(8'h83);
    send(8'h03); send(8'h02); send(8'h00); send(8'h50); send(8'h00);
    send(8'h11); send(8'h22);
    wait_idle("wotf_nack");

    // Retry exhaustion on AH, payload drained
    frm(4'd3, 8'h02); frm(4'd8, 8'h04);
    frm(4'd8, 8'h12); frm(4'd8, 8'h12); frm(4'd8, 8'h12); frm(4'd8, 8'h12);
    ack_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_rsp.push_back(8'hE3);
    send(8'h03); send(8'h04); send(8'h12); send(8'h34); send(8'h56);
    send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
    wait_idle("retry_fail");
    chk("ack_plan_used", ack_q.size(), 0);

    // Bad opcode
    exp_rsp.push_back(8'hF0);
    send(8'h07);
    wait_idle("bad_op");

    // ROTF N=0 with response stalled for 50 cycles
    @(posedge clk);
    #2 rsp_ready = 1'b0;
    send(8'h02); send(8'h00); send(8'h11); send(8'h22); send(8'h33);
    t = 0;
    while (!rsp_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("stall_rsp_seen", 32'(rsp_valid), 32'd1);
    held   = rsp_data;
    stable = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (rsp_data !== held || rsp_valid !== 1'b1) stable = 1'b0;
    end
    chk("stall_stable", 32'(stable), 32'd1);
    exp_rsp.push_back(8'hF2);
    @(posedge clk);
    #2 rsp_ready = 1'b1;
    wait_idle("n_zero");

    // Reset while waiting for an RX byte
    rx_hold = 1'b1;
    frm(4'd3, 8'h01); frm(4'd8, 8'h01); frm(4'd8, 8'h00);
    frm(4'd8, 8'h50); frm(4'd8, 8'h00);
    send(8'h02); send(8'h01); send(8'h00); send(8'h50); send(8'h00);
    t = 0;
    while (!rx_start && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("rst_rx_started", 32'(rx_start), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_outputs",
        {busy, cmd_ready, rsp_valid, tx_start, rx_start, entry_start,
         rsp_data, tx_data, tx_nbits}, 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    rx_hold = 1'b0;
    repeat (30) @(negedge clk);
    chk("midrst_idle", {busy, rsp_valid}, 32'd0);
    chk("midrst_tx_left", exp_tx.size(), 0);

    // Recovery after the abort
    frm(4'd3, 8'h00);
    exp_rsp.push_back(8'h81);
    send(8'h01);
    wait_idle("srst_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
